// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and default width.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple-carry arithmetic chains.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_subtractor.sv
// N-bit ripple subtractor A - B built from full_adder cells (B inverted, carry-in 1).
module ripple_subtractor #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] DIFF,
    output logic         NOBORROW
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a    (A[i]),
            .b    (~B[i]),
            .cin  (carry[i]),
            .sum  (DIFF[i]),
            .cout (carry[i+1])
        );
    end

    // Final carry-out set means A >= B.
    assign NOBORROW = carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, START/DONE handshake.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUO,
    output logic [WIDTH-1:0] REM,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV0
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    logic [WIDTH:0]     r;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   d;
    logic [CW-1:0]      cnt;

    logic [2*WIDTH:0]   rq_sh;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH-1:0]   q_sh;
    logic [WIDTH:0]     t;
    logic               noborrow;
    logic [WIDTH:0]     r_next;
    logic [WIDTH-1:0]   q_next;

    // R[WIDTH] is always 0 between steps, so dropping it in the shift loses nothing.
    always_comb begin
        rq_sh = {r, q} << 1;
        r_sh  = rq_sh[2*WIDTH:WIDTH];
        q_sh  = rq_sh[WIDTH-1:0];
    end

    ripple_subtractor #(.N(WIDTH + 1)) u_sub (
        .A        (r_sh),
        .B        ({1'b0, d}),
        .DIFF     (t),
        .NOBORROW (noborrow)
    );

    always_comb begin
        r_next = noborrow ? t : r_sh;
        q_next = {q_sh[WIDTH-1:1], noborrow};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            cnt   <= '0;
            QUO   <= '0;
            REM   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            DIV0  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (DIVISOR != '0) begin
                            d     <= DIVISOR;
                            r     <= '0;
                            q     <= DIVIDEND;
                            cnt   <= CW'(WIDTH - 1);
                            BUSY  <= 1'b1;
                            state <= RUN;
                        end else begin
                            QUO   <= '1;
                            REM   <= DIVIDEND;
                            DIV0  <= 1'b1;
                            DONE  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        QUO   <= q_next;
                        REM   <= r_next[WIDTH-1:0];
                        DIV0  <= 1'b0;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus random operands vs. a plain-arithmetic model.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         START;
    logic [W-1:0] DIVIDEND;
    logic [W-1:0] DIVISOR;
    logic [W-1:0] QUO;
    logic [W-1:0] REM;
    logic         BUSY;
    logic         DONE;
    logic         DIV0;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    res_t exq[$];

    always #5 CLK = ~CLK;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .QUO      (QUO),
        .REM      (REM),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DIV0     (DIV0)
    );

    function automatic logic [W-1:0] ref_quo(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? {W{1'b1}} : a / b;
    endfunction

    function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == 0) ? a : a % b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transaction: caller is between edges with the DUT idle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int           lat;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        eq       = ref_quo(a, b);
        er       = ref_rem(a, b);
        START    = 1'b1;
        DIVIDEND = a;
        DIVISOR  = b;
        @(posedge CLK);
        #1;
        START    = 1'b0;
        DIVIDEND = W'($urandom);
        DIVISOR  = W'($urandom);
        lat      = 1;
        if (b != 0) check({tag, ".busy_start"}, BUSY, 1);
        while (!DONE && lat < 4 * W) begin
            check({tag, ".busy_run"}, BUSY, 1);
            @(posedge CLK);
            #1;
            lat++;
        end
        check({tag, ".latency"}, lat, (b == 0) ? 1 : W + 1);
        check({tag, ".done"}, DONE, 1);
        check({tag, ".busy_end"}, BUSY, 0);
        check({tag, ".quo"}, QUO, eq);
        check({tag, ".rem"}, REM, er);
        check({tag, ".div0"}, DIV0, (b == 0) ? 1 : 0);
        @(posedge CLK);
        #1;
        check({tag, ".done_fall"}, DONE, 0);
        check({tag, ".quo_hold"}, QUO, eq);
        check({tag, ".rem_hold"}, REM, er);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        int           dones;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        res_t         exp_res;

        RST_N    = 1'b0;
        START    = 1'b0;
        DIVIDEND = '0;
        DIVISOR  = '0;
        #1;
        check("reset.quo", QUO, 0);
        check("reset.rem", REM, 0);
        check("reset.busy", BUSY, 0);
        check("reset.done", DONE, 0);
        check("reset.div0", DIV0, 0);
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        do_op(4'd13, 4'd3, "d13_3");
        do_op(4'd15, 4'd1, "d15_1");
        do_op(4'd7, 4'd9, "d7_9");
        do_op(4'd15, 4'd15, "d15_15");
        do_op(4'd5, 4'd0, "d5_0");
        do_op(4'd6, 4'd2, "d6_2");

        // START re-asserted with other operands during RUN must be ignored.
        START    = 1'b1;
        DIVIDEND = 4'd13;
        DIVISOR  = 4'd3;
        @(posedge CLK);
        #1;
        DIVIDEND = 4'd2;
        DIVISOR  = 4'd1;
        dones    = 0;
        for (int i = 0; i < W; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) dones++;
        end
        START = 1'b0;
        check("ignore.quo", QUO, 4);
        check("ignore.rem", REM, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) dones++;
        end
        check("ignore.done_count", dones, 1);
        check("ignore.quo_after", QUO, 4);
        check("ignore.rem_after", REM, 1);

        // Asynchronous reset in the middle of RUN.
        START    = 1'b1;
        DIVIDEND = 4'd15;
        DIVISOR  = 4'd2;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        #4;
        RST_N = 1'b0;
        #1;
        check("midrst.quo", QUO, 0);
        check("midrst.rem", REM, 0);
        check("midrst.busy", BUSY, 0);
        check("midrst.done", DONE, 0);
        check("midrst.div0", DIV0, 0);
        #7;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst.idle_done", DONE, 0);
        do_op(4'd9, 4'd4, "d9_4");

        // Random operands, divisor zero included.
        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = (n % 7 == 3) ? '0 : W'($urandom);
            do_op(ra, rb, "rand");
        end

        // START held high: a new operation every W+2 edges.
        START    = 1'b1;
        DIVIDEND = W'($urandom);
        DIVISOR  = W'($urandom_range(1, (1 << W) - 1));
        for (int k = 0; k < 3 * (W + 2); k++) begin
            if (k % (W + 2) == 0) exq.push_back('{ref_quo(DIVIDEND, DIVISOR), ref_rem(DIVIDEND, DIVISOR)});
            @(posedge CLK);
            #1;
            DIVIDEND = W'($urandom);
            DIVISOR  = W'($urandom_range(1, (1 << W) - 1));
            if (k % (W + 2) == W) begin
                check("b2b.done", DONE, 1);
                if (exq.size() > 0) begin
                    exp_res = exq.pop_front();
                    last_q  = exp_res.q;
                    last_r  = exp_res.r;
                end
            end else begin
                check("b2b.no_done", DONE, 0);
            end
            check("b2b.quo", QUO, last_q);
            check("b2b.rem", REM, last_r);
        end
        START = 1'b0;
        @(posedge CLK);
        #1;
        check("b2b.final_done", DONE, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
